am_search_ctrl: RTL and testbench

Sequencer and argmax tracker for one associative-memory (AM) similarity search. On start, it sweeps AM class addresses and drives the valid/address side of the bit counter. It consumes the per-class similarity scores the bit counter returns, tracks the best-scoring class, and presents the winner through a valid/ready result port. It sits between the top-level HDC controller and the AM/bit-counter datapath.

---
 rtl/am_search_pkg.sv | 32 +++
 rtl/am_rd_delay.sv | 53 +++++
 rtl/am_search_ctrl.sv | 154 +++++++++++++++
 tb/tb_am_search_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/am_search_pkg.sv
// ============================================================================
// Module : am_search_pkg
// Brief  : Shared types and helpers for the AM similarity-search controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package am_search_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int AM_ADDR_W_DEFAULT = 13;
    localparam int SCORE_W_DEFAULT   = 11;

    // Score width tracks the bit-counter output width for an N-bit hypervector.
    function automatic int score_w(input int n);
        return $clog2(n);
    endfunction

    typedef struct packed {
        logic [AM_ADDR_W_DEFAULT-1:0] cls;
        logic [SCORE_W_DEFAULT-1:0]   score;
    } am_result_t;

endpackage

`default_nettype wire

// File: rtl/am_rd_delay.sv
// ============================================================================
// Module : am_rd_delay
// Brief  : LATENCY-stage valid+address pipe matching the AM read latency.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module am_rd_delay #(
    parameter int LATENCY = 1,
    parameter int ADDR_W  = 13
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    input  logic [ADDR_W-1:0] in_addr_i,
    output logic              out_valid_o,
    output logic [ADDR_W-1:0] out_addr_o
);

    generate
        if (LATENCY == 0) begin : g_comb
            logic unused_clk_rst;
            assign unused_clk_rst = clk_i ^ rst_ni;
            assign out_valid_o    = in_valid_i;
            assign out_addr_o     = in_addr_i;
        end else begin : g_pipe
            logic [LATENCY-1:0] vld_q;
            logic [ADDR_W-1:0]  addr_q [LATENCY];

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    vld_q <= '0;
                    for (int i = 0; i < LATENCY; i++) begin
                        addr_q[i] <= '0;
                    end
                end else begin
                    vld_q[0]  <= in_valid_i;
                    addr_q[0] <= in_addr_i;
                    for (int i = 1; i < LATENCY; i++) begin
                        vld_q[i]  <= vld_q[i-1];
                        addr_q[i] <= addr_q[i-1];
                    end
                end
            end

            assign out_valid_o = vld_q[LATENCY-1];
            assign out_addr_o  = addr_q[LATENCY-1];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/am_search_ctrl.sv
// ============================================================================
// Module : am_search_ctrl
// Brief  : AM search sequencer and argmax tracker with valid/ready result.
//          Define AM_SEARCH_THRESH_EN to add thresh_i / result_hit_o.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module am_search_ctrl
    import am_search_pkg::*;
#(
    parameter  int N             = 2048,
    parameter  int AM_ADDR_WIDTH = 13,
    parameter  int NUM_CLASSES   = 26,
    parameter  int AM_LATENCY    = 1,
    localparam int SCORE_W       = score_w(N)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    output logic                     busy_o,
    output logic                     am_rd_en_o,
    output logic [AM_ADDR_WIDTH-1:0] am_addr_o,
    output logic                     bc_valid_o,
    output logic [AM_ADDR_WIDTH-1:0] bc_addr_o,
    input  logic                     bc_valid_i,
    input  logic [SCORE_W-1:0]       bc_count_i,
    input  logic [AM_ADDR_WIDTH-1:0] bc_addr_i,
    output logic                     result_valid_o,
    input  logic                     result_ready_i,
    output logic [AM_ADDR_WIDTH-1:0] result_class_o,
    output logic [SCORE_W-1:0]       result_score_o
`ifdef AM_SEARCH_THRESH_EN
    ,
    input  logic [SCORE_W-1:0]       thresh_i,
    output logic                     result_hit_o
`endif
);

    typedef struct packed {
        logic [AM_ADDR_WIDTH-1:0] cls;
        logic [SCORE_W-1:0]       score;
    } result_t;

    localparam logic [AM_ADDR_WIDTH-1:0] c_last_addr = AM_ADDR_WIDTH'(NUM_CLASSES - 1);
    localparam logic [AM_ADDR_WIDTH:0]   c_num_cls   = (AM_ADDR_WIDTH + 1)'(NUM_CLASSES);

    state_e                   state_q, state_d;
    logic [AM_ADDR_WIDTH-1:0] issue_cnt_q, issue_cnt_d;
    logic [AM_ADDR_WIDTH:0]   recv_cnt_q, recv_cnt_d;
    result_t                  best_q, best_d;
    logic                     w_capture;
    logic                     w_take;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            best_q      <= '0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            best_q      <= best_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        recv_cnt_d  = recv_cnt_q;
        best_d      = best_q;
        w_capture   = bc_valid_i && ((state_q == ISSUE) || (state_q == DRAIN));
        // First score always loads; later ones only on a strict win so ties keep the lower address.
        w_take      = w_capture && ((recv_cnt_q == '0) || (bc_count_i > best_q.score));

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d     = ISSUE;
                    issue_cnt_d = '0;
                    recv_cnt_d  = '0;
                    best_d      = '0;
                end
            end
            ISSUE: begin
                if (issue_cnt_q == c_last_addr) begin
                    state_d = DRAIN;
                end else begin
                    issue_cnt_d = issue_cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (recv_cnt_q == c_num_cls) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (result_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (w_take) begin
            best_d.score = bc_count_i;
            best_d.cls   = bc_addr_i;
        end
        if (w_capture) begin
            recv_cnt_d = recv_cnt_q + 1'b1;
        end
    end

    assign busy_o         = (state_q != IDLE);
    assign am_rd_en_o     = (state_q == ISSUE);
    assign am_addr_o      = am_rd_en_o ? issue_cnt_q : '0;
    assign result_valid_o = (state_q == DONE);
    assign result_class_o = result_valid_o ? best_q.cls : '0;
    assign result_score_o = result_valid_o ? best_q.score : '0;

    am_rd_delay #(
        .LATENCY (AM_LATENCY),
        .ADDR_W  (AM_ADDR_WIDTH)
    ) u_rd_delay (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (am_rd_en_o),
        .in_addr_i   (am_addr_o),
        .out_valid_o (bc_valid_o),
        .out_addr_o  (bc_addr_o)
    );

`ifdef AM_SEARCH_THRESH_EN
    logic hit_q;

    // Latched on DONE entry, when the best score is final, so thresh_i may move afterwards.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hit_q <= 1'b0;
        end else if ((state_q == DRAIN) && (state_d == DONE)) begin
            hit_q <= (best_q.score >= thresh_i);
        end else if (state_q != DONE) begin
            hit_q <= 1'b0;
        end
    end

    assign result_hit_o = hit_q & result_valid_o;
`endif

endmodule

`default_nettype wire

// File: tb/tb_am_search_ctrl.sv
// ============================================================================
// Module : tb_am_search_ctrl
// Brief  : Directed self-checking bench for am_search_ctrl (default and
//          NUM_CLASSES=1/AM_LATENCY=0 instances); AM_SEARCH_THRESH_EN aware.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_am_search_ctrl;

    logic        clk;
    logic        rst_n;

    logic        start0, ready0, busy0, rd0, bcv_o0, bcv_i0, rv0;
    logic [12:0] addr0, bca_o0, bca_i0, rc0;
    logic [10:0] bcc_i0, rs0;

    logic        start1, ready1, busy1, rd1, bcv_o1, bcv_i1, rv1;
    logic [12:0] addr1, bca_o1, bca_i1, rc1;
    logic [10:0] bcc_i1, rs1;

`ifdef AM_SEARCH_THRESH_EN
    logic [10:0] thresh;
    logic        hit0, hit1;
`endif

    // Bit-counter model: one register stage, score looked up from a table.
    logic [10:0] score_tab [32];
    logic        m_vld  = 1'b0;
    logic [12:0] m_addr = '0;
    logic [10:0] m_cnt  = '0;
    logic        inj_vld;
    logic [12:0] inj_addr;
    logic [10:0] inj_cnt;

    always @(posedge clk) begin
        m_vld  <= bcv_o0;
        m_addr <= bca_o0;
        m_cnt  <= score_tab[bca_o0[4:0]];
    end
    assign bcv_i0 = m_vld | inj_vld;
    assign bca_i0 = inj_vld ? inj_addr : m_addr;
    assign bcc_i0 = inj_vld ? inj_cnt : m_cnt;

    logic        m1_vld  = 1'b0;
    logic [12:0] m1_addr = '0;
    always @(posedge clk) begin
        m1_vld  <= bcv_o1;
        m1_addr <= bca_o1;
    end
    assign bcv_i1 = m1_vld;
    assign bca_i1 = m1_addr;
    assign bcc_i1 = 11'd2047;

    am_search_ctrl u_dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start0),
        .busy_o         (busy0),
        .am_rd_en_o     (rd0),
        .am_addr_o      (addr0),
        .bc_valid_o     (bcv_o0),
        .bc_addr_o      (bca_o0),
        .bc_valid_i     (bcv_i0),
        .bc_count_i     (bcc_i0),
        .bc_addr_i      (bca_i0),
        .result_valid_o (rv0),
        .result_ready_i (ready0),
        .result_class_o (rc0),
        .result_score_o (rs0)
`ifdef AM_SEARCH_THRESH_EN
        ,
        .thresh_i       (thresh),
        .result_hit_o   (hit0)
`endif
    );

    am_search_ctrl #(
        .NUM_CLASSES (1),
        .AM_LATENCY  (0)
    ) u_dut1 (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start1),
        .busy_o         (busy1),
        .am_rd_en_o     (rd1),
        .am_addr_o      (addr1),
        .bc_valid_o     (bcv_o1),
        .bc_addr_o      (bca_o1),
        .bc_valid_i     (bcv_i1),
        .bc_count_i     (bcc_i1),
        .bc_addr_i      (bca_i1),
        .result_valid_o (rv1),
        .result_ready_i (ready1),
        .result_class_o (rc1),
        .result_score_o (rs1)
`ifdef AM_SEARCH_THRESH_EN
        ,
        .thresh_i       (thresh),
        .result_hit_o   (hit1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pulse start on the default instance and count cycles until result_valid.
    task automatic run0(input bit inj, output int cyc, output int rd);
        start0 = 1'b1;
        if (inj) begin
            inj_vld  = 1'b1;
            inj_addr = 13'd9;
            inj_cnt  = 11'd2047;
        end
        @(negedge clk);
        start0  = 1'b0;
        inj_vld = 1'b0;
        cyc = 1;
        rd  = 0;
        while (!rv0 && cyc < 100) begin
            if (rd0) rd++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic set_ramp();
        for (int i = 0; i < 32; i++) score_tab[i] = 11'(100 + i);
        score_tab[7] = 11'd2000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc, rd;
        bit  hold_ok;

        rst_n = 1'b0; start0 = 1'b0; ready0 = 1'b0; start1 = 1'b0; ready1 = 1'b0;
        inj_vld = 1'b0; inj_addr = '0; inj_cnt = '0;
`ifdef AM_SEARCH_THRESH_EN
        thresh = 11'd0;
`endif
        for (int i = 0; i < 32; i++) score_tab[i] = '0;

        tick(2);
        chk("rst_busy",      32'(busy0),  0);
        chk("rst_rd_en",     32'(rd0),    0);
        chk("rst_bc_valid",  32'(bcv_o0), 0);
        chk("rst_res_valid", 32'(rv0),    0);
        chk("rst_res_class", 32'(rc0),    0);
        chk("rst_res_score", 32'(rs0),    0);
        chk("rst_busy1",     32'(busy1),  0);
`ifdef AM_SEARCH_THRESH_EN
        chk("rst_hit",       32'(hit0),   0);
`endif
        rst_n = 1'b1;
        tick(1);

        // Ramp scores with a single clear winner at class 7.
        set_ramp();
        run0(1'b0, cyc, rd);
        chk("t1_latency",  32'(cyc), 30);
        chk("t1_rd_count", 32'(rd),  26);
        chk("t1_class",    32'(rc0), 7);
        chk("t1_score",    32'(rs0), 2000);

        // Hold in DONE with ready low; a start and a stray high score must not disturb it.
        hold_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            start0  = (i == 3);
            inj_vld = (i == 6);
            inj_addr = 13'd3;
            inj_cnt  = 11'd2047;
            tick(1);
            if (!(rv0 === 1'b1 && rc0 === 13'd7 && rs0 === 11'd2000)) hold_ok = 1'b0;
        end
        start0 = 1'b0; inj_vld = 1'b0;
        chk("t1_hold_stable", 32'(hold_ok), 1);
        chk("t1_hold_busy",   32'(busy0),   1);
        ready0 = 1'b1;
        tick(1);
        chk("t1_release_valid", 32'(rv0),   0);
        chk("t1_release_busy",  32'(busy0), 0);
        tick(1);
        chk("t1_no_queue", 32'(busy0), 0);

        // All scores tied: lowest address wins. ready stays high throughout.
        for (int i = 0; i < 32; i++) score_tab[i] = 11'd512;
        run0(1'b0, cyc, rd);
        chk("t2_latency", 32'(cyc), 30);
        chk("t2_class",   32'(rc0), 0);
        chk("t2_score",   32'(rs0), 512);
        start0 = 1'b1;
        tick(1);
        start0 = 1'b0;
        chk("t2_hs_valid",       32'(rv0),   0);
        chk("t2_hs_start_busy",  32'(busy0), 0);
        tick(1);
        chk("t2_idle_busy", 32'(busy0), 0);
        ready0 = 1'b0;

        // Reset asserted at cycle 10 of a sweep.
        set_ramp();
        start0 = 1'b1;
        tick(1);
        start0 = 1'b0;
        tick(9);
        #2 rst_n = 1'b0;
        #1;
        chk("t3_rst_busy",   32'(busy0),  0);
        chk("t3_rst_rd_en",  32'(rd0),    0);
        chk("t3_rst_addr",   32'(addr0),  0);
        chk("t3_rst_bc_vld", 32'(bcv_o0), 0);
        tick(1);
        rst_n = 1'b1;
        inj_vld = 1'b1; inj_addr = 13'd9; inj_cnt = 11'd2047;
        tick(2);
        inj_vld = 1'b0;
        chk("t3_stray_busy",  32'(busy0), 0);
        chk("t3_stray_valid", 32'(rv0),   0);
        run0(1'b1, cyc, rd);
        chk("t3_latency", 32'(cyc), 30);
        chk("t3_class",   32'(rc0), 7);
        chk("t3_score",   32'(rs0), 2000);
        ready0 = 1'b1;
        tick(1);
        ready0 = 1'b0;
        chk("t3_release", 32'(rv0), 0);

        // Single-class instance with a combinational delay line.
        start1 = 1'b1;
        tick(1);
        start1 = 1'b0;
        cyc = 1;
        rd  = 0;
        chk("t4_bc_valid_comb", 32'(bcv_o1), 1);
        chk("t4_bc_addr_comb",  32'(bca_o1), 0);
        while (!rv1 && cyc < 100) begin
            if (rd1) rd++;
            tick(1);
            cyc++;
        end
        chk("t4_latency",  32'(cyc), 4);
        chk("t4_rd_count", 32'(rd),  1);
        chk("t4_class",    32'(rc1), 0);
        chk("t4_score",    32'(rs1), 2047);
        ready1 = 1'b1;
        tick(1);
        ready1 = 1'b0;
        chk("t4_release", 32'(rv1), 0);

`ifdef AM_SEARCH_THRESH_EN
        // Threshold compare is inclusive: 1023 misses, 1024 hits.
        thresh = 11'd1024;
        for (int i = 0; i < 32; i++) score_tab[i] = '0;
        score_tab[4] = 11'd1023;
        run0(1'b0, cyc, rd);
        chk("t5_valid_a", 32'(rv0),  1);
        chk("t5_class_a", 32'(rc0),  4);
        chk("t5_hit_a",   32'(hit0), 0);
        ready0 = 1'b1;
        tick(1);
        ready0 = 1'b0;
        score_tab[4] = 11'd1024;
        run0(1'b0, cyc, rd);
        chk("t5_valid_b", 32'(rv0),  1);
        chk("t5_score_b", 32'(rs0),  1024);
        chk("t5_hit_b",   32'(hit0), 1);
        ready0 = 1'b1;
        tick(1);
        ready0 = 1'b0;
        chk("t5_hit_clear", 32'(hit0), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
